// File: rtl/cpu_atomic_pkg.sv
// Shared types and constants for the load-link / store-conditional unit.
package cpu_atomic_pkg;

    typedef enum logic {
        LINK_IDLE   = 1'b0,
        LINK_ACTIVE = 1'b1
    } link_state_t;

    localparam logic ONE  = 1'b1;
    localparam logic ZERO = 1'b0;

    localparam int DEF_LINK_LSB = 2;

endpackage

// File: rtl/ll_timeout_ctr.sv
// Link lifetime counter. It is cleared by an LL and counts every cycle the link is held.
// o_expire is high in the last allowed cycle. The top instantiates it only when LL_TIMEOUT_EN is defined.
module ll_timeout_ctr
    import cpu_atomic_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_BITS       = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst_,
    input  logic i_clear,
    input  logic i_active,
    output logic o_expire
);

    logic [CNT_BITS-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_active) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_expire = i_active & (r_cnt == CNT_BITS'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ll_sc_link_unit.sv
// Memory-stage LL/SC reservation tracker. It gates the SC store enable and registers the SC outcome.
// Optional link timeout: define LL_TIMEOUT_EN.
module ll_sc_link_unit
    import cpu_atomic_pkg::*;
#(
    parameter int BITS           = 32,
    parameter int LINK_LSB       = DEF_LINK_LSB,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_BITS       = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 atomic_s3,
    input  logic                 load_link_s3,
    input  logic                 check_link_s3,
    input  logic                 mem_rw_s3,
    input  logic [BITS-1:0]      mem_addr,
    input  logic                 stall,
    input  logic                 halt_s3,
    input  logic                 link_clr,
    input  logic                 snoop_valid,
    input  logic [BITS-1:0]      snoop_addr,
    output logic                 mem_wr_,
    output logic                 link_valid,
    output logic [BITS-LINK_LSB-1:0] link_addr,
    output logic                 sc_result_s4,
    output logic                 sc_done_s4
);

    link_state_t r_state, w_next;
    logic [BITS-LINK_LSB-1:0] r_link_addr;
    logic r_sc_result, r_sc_done;

    logic w_sc, w_ll, w_st, w_match, w_snoop_hit, w_snoop_new, w_sc_ok;
    logic w_active, w_load_addr, w_expire;
    logic w_unused_lo;

    assign w_unused_lo = ^{mem_addr[LINK_LSB-1:0], snoop_addr[LINK_LSB-1:0]};

    // SC takes precedence over LL when both are decoded in the same cycle.
    assign w_sc = ~stall & atomic_s3 & check_link_s3 & ~mem_rw_s3;
    assign w_ll = ~stall & atomic_s3 & ~load_link_s3 & ~w_sc;
    assign w_st = ~stall & ~mem_rw_s3 & ~w_sc;

    assign w_active    = (r_state == LINK_ACTIVE);
    assign w_match     = (mem_addr[BITS-1:LINK_LSB] == r_link_addr);
    assign w_snoop_hit = snoop_valid & (snoop_addr[BITS-1:LINK_LSB] == r_link_addr);
    assign w_snoop_new = snoop_valid &
                         (snoop_addr[BITS-1:LINK_LSB] == mem_addr[BITS-1:LINK_LSB]);

    assign w_sc_ok = w_sc & w_active & w_match & ~w_snoop_hit & ~link_clr;

    assign mem_wr_ = ~rst_ | mem_rw_s3 | stall | (w_sc & ~w_sc_ok);

`ifdef LL_TIMEOUT_EN
    ll_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_BITS       (CNT_BITS)
    ) u_timeout (
        .clk      (clk),
        .rst_     (rst_),
        .i_clear  (w_ll),
        .i_active (w_active),
        .o_expire (w_expire)
    );
`else
    assign w_expire = ZERO;
`endif

    always_comb begin
        w_next      = r_state;
        w_load_addr = ZERO;
        if (link_clr | halt_s3) begin
            w_next = LINK_IDLE;
        end else if (w_snoop_hit & w_active) begin
            w_next = LINK_IDLE;
        end else if (w_expire) begin
            w_next = LINK_IDLE;
        end else if (w_sc) begin
            w_next = LINK_IDLE;
        end else if (w_st & w_match) begin
            w_next = LINK_IDLE;
        end else if (w_ll) begin
            // A same-cycle snoop to the granule being linked makes the new link stale on arrival.
            w_load_addr = ONE;
            w_next      = w_snoop_new ? LINK_IDLE : LINK_ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state     <= LINK_IDLE;
            r_link_addr <= '0;
            r_sc_result <= ZERO;
            r_sc_done   <= ZERO;
        end else begin
            r_state   <= w_next;
            r_sc_done <= w_sc;
            if (w_load_addr) r_link_addr <= mem_addr[BITS-1:LINK_LSB];
            if (w_sc)        r_sc_result <= w_sc_ok;
        end
    end

    assign link_valid   = w_active;
    assign link_addr    = r_link_addr;
    assign sc_result_s4 = r_sc_result;
    assign sc_done_s4   = r_sc_done;

endmodule

// File: doc/ll_sc_link_unit.md
Name: ll_sc_link_unit

Overview:
- Memory-stage responder for the load-link / store-conditional protocol.
- The ID/EX pipeline register issues load_link_s3, check_link_s3, atomic_s3 and mem_rw_s3. This block consumes them and tracks one link reservation.
- Gates the store write-enable of a store-conditional (SC) and returns a registered success flag for writeback.
- Sits between the EX/MEM boundary and the data-memory port.

Parameters:
- BITS, 32, data/address width.
- LINK_LSB, 2, low address bits ignored for granule match (word granule).
- TIMEOUT_CYCLES, 64, link lifetime in cycles; used only with LL_TIMEOUT_EN.
- CNT_BITS, $clog2(TIMEOUT_CYCLES), timeout counter width.

Ports:
- clk  in  1  system clock.
- rst_  in  1  asynchronous active-low reset.
- atomic_s3  in  1  instruction is LL or SC.
- load_link_s3  in  1  active-low; LL executing.
- check_link_s3  in  1  SC executing.
- mem_rw_s3  in  1  active-low memory write request.
- mem_addr  in  BITS  effective address (ALU result).
- stall  in  1  pipeline hold; stage inputs are ignored.
- halt_s3  in  1  halt reached stage 3.
- link_clr  in  1  exception/return clears the reservation.
- snoop_valid  in  1  another agent wrote memory.
- snoop_addr  in  BITS  address of that write.
- mem_wr_  out  1  active-low gated write enable to data memory.
- link_valid  out  1  reservation held.
- link_addr  out  BITS-LINK_LSB  reserved granule.
- sc_result_s4  out  1  registered SC outcome (1 = pass).
- sc_done_s4  out  1  one-cycle pulse; sc_result_s4 is valid.

Behaviour:
- Reset (async, rst_=0):
  - state=LINK_IDLE, link_addr=0, sc_result_s4=0, sc_done_s4=0.
  - Timeout counter=0.
  - link_valid=0.
  - mem_wr_=1 (combinational, forced high when rst_=0).
- Granule match: mem_addr[BITS-1:LINK_LSB]==link_addr. Snoop hit uses snoop_addr the same way.
- Decoded events, valid only when stall=0:
  - LL = atomic_s3 & ~load_link_s3.
  - SC = atomic_s3 & check_link_s3 & ~mem_rw_s3.
  - ST = ~mem_rw_s3 & ~SC.
- sc_ok (combinational) = SC & state==LINK_ACTIVE & match & ~(snoop_valid & snoop hit) & ~link_clr.
- mem_wr_ = mem_rw_s3 | stall | (SC & ~sc_ok). A failed SC never writes. Same-cycle gating, zero latency.
- FSM states: LINK_IDLE, LINK_ACTIVE. Next-state priority, highest first:
  1. link_clr or halt_s3 -> LINK_IDLE. Applies even when stall=1.
  2. snoop_valid & snoop hit & state==LINK_ACTIVE -> LINK_IDLE. Applies even when stall=1.
  3. SC -> LINK_IDLE, pass or fail.
  4. ST & match -> LINK_IDLE (own plain store breaks the link).
  5. LL -> LINK_ACTIVE, link_addr <= mem_addr[BITS-1:LINK_LSB]. Relink from LINK_ACTIVE overwrites the address.
  6. Otherwise hold.
- LL with a same-cycle snoop to the new granule: the snoop wins and the state ends LINK_IDLE, which is conservative.
- link_valid = (state==LINK_ACTIVE).
- SC writeback: on SC, next edge sets sc_done_s4=1 and sc_result_s4=sc_ok. Otherwise sc_done_s4=0 and sc_result_s4 holds.
- LL/SC asserted together: illegal decode; treated as SC.
- Reset mid-SC: the write is suppressed (mem_wr_=1), no sc_done_s4, link lost.

Optional Feature:
- Macro: LL_TIMEOUT_EN.
- Defined:
  - Counter clears on LL and counts each cycle in LINK_ACTIVE.
  - On reaching TIMEOUT_CYCLES-1 the state goes to LINK_IDLE at priority just below snoop.
  - An SC in the expiry cycle still passes; the timeout takes effect the next cycle.
- Undefined: no counter; the link persists until a clearing event.

Decomposition:
- Package cpu_atomic_pkg holds:
  - enum link_state_t {LINK_IDLE, LINK_ACTIVE};
  - localparams ONE/ZERO;
  - default LINK_LSB.
- One sub-module: ll_timeout_ctr (counter plus expire flag), instantiated only under LL_TIMEOUT_EN.

Test Plan:
1. LL at 0x1000, then SC at 0x1004 (different word) -> mem_wr_=1, sc_done_s4=1, sc_result_s4=0, link_valid=0.
2. LL at 0x2000, then SC at 0x2000 -> mem_wr_=0 in the SC cycle, sc_result_s4=1, then link_valid=0.
3. LL at 0x3000, snoop_valid with snoop_addr 0x3002 during stall=1, then SC 0x3000 -> sc_result_s4=0.
4. LL at 0x4000, plain store to 0x4000, then SC at 0x4000 -> store writes, SC fails with mem_wr_=1.
5. LL at 0x5000, rst_ pulsed low async mid-cycle -> link_valid=0 immediately, sc_done_s4=0, next SC fails.
6. With LL_TIMEOUT_EN and TIMEOUT_CYCLES=8: LL, wait 8 cycles, then SC -> sc_result_s4=0. LL, wait 7 cycles, then SC -> 1.
